main_control_fsm: RTL

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/mips_ctrl_pkg.sv | 33 +++
 rtl/main_control_fsm_alu_decoder.sv | 25 ++
 rtl/main_control_fsm.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode/funct and select encodings shared by the multicycle MIPS control FSM.
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;
endpackage

// File: rtl/main_control_fsm_alu_decoder.sv
// alu_decoder: maps the FSM's alu_op and the R-type funct field to an ALU control code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_illegal
);
  always_comb begin
    alu_control = ALUC_ADD;
    funct_illegal = 1'b0;
    if (alu_op == ALUOP_SUB) alu_control = ALUC_SUB;
    else if (alu_op == ALUOP_FUNCT) begin
      case (funct)
        F_ADD:   alu_control = ALUC_ADD;
        F_SUB:   alu_control = ALUC_SUB;
        F_AND:   alu_control = ALUC_AND;
        F_OR:    alu_control = ALUC_OR;
        F_SLT:   alu_control = ALUC_SLT;
        default: funct_illegal = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle MIPS main controller (lw/sw/R-type/beq/addi/j) with Moore output decode.
module main_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pc_en,
  output logic                iord,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [2:0]          alu_control,
  output logic                illegal_op,
  output logic [3:0]          state_dbg
);
  state_e state_q, state_d, cur;
  logic [1:0] alu_op;
  logic pc_write, branch, mw, iw, rw, op_ill, funct_ill;
  always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;
  // During reset the selects decode as FETCH; enables are masked below.
  always_comb begin
    cur = rst ? S_FETCH : state_q;
    state_d = S_FETCH;
    iord = 1'b0;
    mw = 1'b0;
    iw = 1'b0;
    rw = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REGB;
    pc_source = PCS_ALU;
    alu_op = ALUOP_ADD;
    pc_write = 1'b0;
    branch = 1'b0;
    op_ill = 1'b0;
    case (cur)
      S_FETCH: begin
        iw = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      op_ill = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        rw = 1'b1;
      end
      S_MEMWR: begin
        iord = 1'b1;
        mw = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_FUNCT;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst = 1'b1;
        rw = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_SUB;
        pc_source = PCS_ALUOUT;
        branch = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: rw = 1'b1;
      S_JEX: begin
        pc_source = PCS_JUMP;
        pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end
  alu_decoder u_alu_decoder (
    .alu_op       (alu_op),
    .funct        (funct),
    .alu_control  (alu_control),
    .funct_illegal(funct_ill)
  );
  assign pc_en      = (pc_write | (branch & zero)) & ~rst;
  assign mem_write  = mw & ~rst;
  assign ir_write   = iw & ~rst;
  assign reg_write  = rw & ~rst;
  assign illegal_op = (op_ill | funct_ill) & ~rst;
  assign state_dbg  = state_q;
endmodule
